// File: rtl/snn_readout_pkg.sv
// Shared definitions for the SNN readout slice.
// Holds the classifier FSM state encoding, the default sizing of the
// readout (neuron count, spike-counter width, window-length width) and a
// helper that sizes an index bus so it is never narrower than one bit.
package snn_readout_pkg;

   localparam int DEF_N  = 2;
   localparam int DEF_CW = 8;
   localparam int DEF_WW = 8;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      COUNT  = 2'd1,
      ARGMAX = 2'd2
   } state_t;

   // A single neuron still needs a one-bit winner port.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for one neuron's spike count.
// Ports:
//   clk   - rising-edge clock
//   reset - asynchronous, active-low reset (0 clears the count)
//   clr   - synchronous clear, takes priority over inc
//   inc   - add one to the count unless it is already all ones
//   count - current count value
module sat_counter
   import snn_readout_pkg::*;
#(
   parameter int CW = DEF_CW
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          clr,
   input  logic          inc,
   output logic [CW-1:0] count
);

   // Holding at all-ones keeps a busy neuron from wrapping back to a small
   // count and losing the argmax.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (inc && (count != '1)) begin
         count <= count + CW'(1);
      end
   end

endmodule

// File: rtl/spike_count_classifier.sv
// Rate-coded readout for the output layer of a two-layer spiking network.
// A window of window_len enabled ticks is counted per neuron, then a
// sequential argmax picks the most active neuron.
// Ports:
//   clk          - rising-edge clock
//   reset        - asynchronous, active-low reset
//   enable       - network tick; spikes are only sampled while high
//   start        - request a new window (honoured only while idle)
//   window_len   - enabled ticks per window, latched on an accepted start
//   spikes_in    - one spike bit per output neuron
//   busy         - high while counting or scanning
//   counts_out   - per-neuron counts, neuron i at [i*CW +: CW]
//   winner       - index of the highest count (lowest index on equality)
//   tie          - another neuron equals the winning count
//   result_valid - one-cycle pulse when winner/tie/counts_out update
module spike_count_classifier
   import snn_readout_pkg::*;
#(
   parameter  int N  = DEF_N,
   parameter  int CW = DEF_CW,
   parameter  int WW = DEF_WW,
   localparam int IW = idx_width(N)
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            enable,
   input  logic            start,
   input  logic [WW-1:0]   window_len,
   input  logic [N-1:0]    spikes_in,
   output logic            busy,
   output logic [N*CW-1:0] counts_out,
   output logic [IW-1:0]   winner,
   output logic            tie,
   output logic            result_valid
);

   state_t state;
   state_t state_next;

   logic          accept;
   logic          cnt_inc;
   logic          last_tick;
   logic          last_scan;

   logic [WW-1:0] win_len_q;
   logic [WW-1:0] tick_cnt;
   logic [IW-1:0] scan_idx;

   logic [CW-1:0] cnt [N];
   logic [N*CW-1:0] cnt_flat;

   logic [CW-1:0] best_val;
   logic [IW-1:0] best_idx;
   logic          best_tie;

   logic [CW-1:0] cur_val;
   logic [CW-1:0] nxt_val;
   logic [IW-1:0] nxt_idx;
   logic          nxt_tie;

   // The window ends on the tick that brings the count up to window_len;
   // COUNT is never entered with a zero length, so the subtraction is safe.
   assign last_tick = (tick_cnt == (win_len_q - WW'(1)));
   assign last_scan = (scan_idx == IW'(N - 1));
   assign busy      = (state != IDLE);

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state and control strobes. A zero-length window skips COUNT and
   // goes straight to the scan so the result still arrives with all zeros.
   always_comb begin
      state_next = state;
      accept     = 1'b0;
      cnt_inc    = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               accept     = 1'b1;
               state_next = (window_len == '0) ? ARGMAX : COUNT;
            end
         end
         COUNT: begin
            if (enable) begin
               cnt_inc = 1'b1;
               if (last_tick) begin
                  state_next = ARGMAX;
               end
            end
         end
         ARGMAX: begin
            if (last_scan) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // One saturating counter per output neuron, cleared when a window starts.
   for (genvar i = 0; i < N; i++) begin : g_cnt
      sat_counter #(
         .CW(CW)
      ) u_cnt (
         .clk  (clk),
         .reset(reset),
         .clr  (accept),
         .inc  (cnt_inc & spikes_in[i]),
         .count(cnt[i])
      );
   end

   // Window length is captured on the accepted start so the caller may
   // change window_len freely while a window is in progress.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         win_len_q <= '0;
         tick_cnt  <= '0;
      end else if (accept) begin
         win_len_q <= window_len;
         tick_cnt  <= '0;
      end else if (cnt_inc) begin
         tick_cnt  <= tick_cnt + WW'(1);
      end
   end

   // One step of the running argmax. Index 0 seeds the running maximum;
   // later indices replace it only when strictly greater, which leaves the
   // lowest index in place on equal counts. The tie flag is dropped whenever
   // a new maximum appears, so it only reflects equality with the final one.
   always_comb begin
      cur_val = cnt[scan_idx];
      nxt_val = best_val;
      nxt_idx = best_idx;
      nxt_tie = best_tie;
      if (scan_idx == '0) begin
         nxt_val = cur_val;
         nxt_idx = '0;
         nxt_tie = 1'b0;
      end else if (cur_val > best_val) begin
         nxt_val = cur_val;
         nxt_idx = scan_idx;
         nxt_tie = 1'b0;
      end else if (cur_val == best_val) begin
         nxt_tie = 1'b1;
      end
   end

   // Scan pointer and running-maximum registers advance once per ARGMAX cycle.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         scan_idx <= '0;
         best_val <= '0;
         best_idx <= '0;
         best_tie <= 1'b0;
      end else if (accept) begin
         scan_idx <= '0;
      end else if (state == ARGMAX) begin
         best_val <= nxt_val;
         best_idx <= nxt_idx;
         best_tie <= nxt_tie;
         scan_idx <= last_scan ? '0 : (scan_idx + IW'(1));
      end
   end

   // Flatten the counter array into the published bus layout.
   always_comb begin
      cnt_flat = '0;
      for (int i = 0; i < N; i++) begin
         cnt_flat[i*CW +: CW] = cnt[i];
      end
   end

   // Results are captured on the last scan step and then held, so a new
   // window clearing the live counters does not disturb what was published.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         result_valid <= 1'b0;
         winner       <= '0;
         tie          <= 1'b0;
         counts_out   <= '0;
      end else begin
         result_valid <= (state == ARGMAX) && last_scan;
         if ((state == ARGMAX) && last_scan) begin
            winner     <= nxt_idx;
            tie        <= nxt_tie;
            counts_out <= cnt_flat;
         end
      end
   end

endmodule

// File: tb/tb_spike_count_classifier.sv
// Directed self-checking bench for spike_count_classifier at N=2, CW=8.
// Inputs are driven 1 time unit after each rising edge and outputs are
// sampled at the same point, well away from the next active edge.
module tb_spike_count_classifier;

   logic        clk = 1'b0;
   logic        reset;
   logic        enable;
   logic        start;
   logic [7:0]  window_len;
   logic [1:0]  spikes_in;
   logic        busy;
   logic [15:0] counts_out;
   logic [0:0]  winner;
   logic        tie;
   logic        result_valid;

   int compare_count  = 0;
   int mismatch_count = 0;
   int rv_count       = 0;
   int rv_base;

   spike_count_classifier #(
      .N (2),
      .CW(8),
      .WW(8)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .enable      (enable),
      .start       (start),
      .window_len  (window_len),
      .spikes_in   (spikes_in),
      .busy        (busy),
      .counts_out  (counts_out),
      .winner      (winner),
      .tie         (tie),
      .result_valid(result_valid)
   );

   // Free-running clock.
   always #5 clk = ~clk;

   // Count result_valid pulses as seen on each rising edge.
   always @(posedge clk) begin
      if (result_valid === 1'b1) begin
         rv_count = rv_count + 1;
      end
   end

   // Hard stop in case the sequence ever stalls.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      compare_count++;
      assert (observed === expected) else begin
         mismatch_count++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic en, input logic st,
                                input logic [7:0] wl, input logic [1:0] sp);
      enable     = en;
      start      = st;
      window_len = wl;
      spikes_in  = sp;
      @(posedge clk);
      #1;
   endtask

   task automatic waitResult(input string tag, input int max_cycles);
      int n;
      n = 0;
      while ((result_valid !== 1'b1) && (n < max_cycles)) begin
         applyStimulus(1'b0, 1'b0, 8'd0, 2'b00);
         n++;
      end
      checkOutput({tag, "_rv"}, 32'(result_valid), 32'd1);
   endtask

   task automatic checkResult(input string tag, input logic [15:0] cnts,
                              input logic w, input logic t);
      checkOutput({tag, "_counts"}, 32'(counts_out), 32'(cnts));
      checkOutput({tag, "_winner"}, 32'(winner), 32'(w));
      checkOutput({tag, "_tie"}, 32'(tie), 32'(t));
   endtask

   initial begin
      reset      = 1'b0;
      enable     = 1'b0;
      start      = 1'b0;
      window_len = 8'd0;
      spikes_in  = 2'b00;
      #12;
      $display("[TB] reset state");
      checkOutput("rst_busy", 32'(busy), 32'd0);
      checkOutput("rst_rv", 32'(result_valid), 32'd0);
      checkResult("rst", 16'h0000, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      reset = 1'b1;
      applyStimulus(1'b0, 1'b0, 8'd0, 2'b00);

      // Scenario 1: four ticks, neuron 0 clearly ahead.
      $display("[TB] scenario 1");
      rv_base = rv_count;
      applyStimulus(1'b1, 1'b1, 8'd4, 2'b00);
      checkOutput("s1_busy", 32'(busy), 32'd1);
      applyStimulus(1'b1, 1'b0, 8'd4, 2'b01);
      applyStimulus(1'b1, 1'b0, 8'd4, 2'b01);
      applyStimulus(1'b1, 1'b0, 8'd4, 2'b11);
      applyStimulus(1'b1, 1'b0, 8'd4, 2'b00);
      applyStimulus(1'b0, 1'b0, 8'd0, 2'b00);
      checkOutput("s1_rv_early", 32'(result_valid), 32'd0);
      applyStimulus(1'b0, 1'b0, 8'd0, 2'b00);
      checkOutput("s1_rv", 32'(result_valid), 32'd1);
      checkResult("s1", 16'h0103, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0, 8'd0, 2'b00);
      checkOutput("s1_rv_drop", 32'(result_valid), 32'd0);
      checkOutput("s1_busy_end", 32'(busy), 32'd0);
      applyStimulus(1'b0, 1'b0, 8'd0, 2'b00);
      checkOutput("s1_pulses", 32'(rv_count - rv_base), 32'd1);
      checkResult("s1_hold", 16'h0103, 1'b0, 1'b0);

      // Scenario 2: gaps in enable are not counted; spikes ignored in scan.
      $display("[TB] scenario 2");
      applyStimulus(1'b0, 1'b1, 8'd3, 2'b10);
      applyStimulus(1'b1, 1'b0, 8'd3, 2'b10);
      applyStimulus(1'b0, 1'b0, 8'd3, 2'b10);
      applyStimulus(1'b1, 1'b0, 8'd3, 2'b10);
      applyStimulus(1'b0, 1'b0, 8'd3, 2'b10);
      checkOutput("s2_busy", 32'(busy), 32'd1);
      applyStimulus(1'b1, 1'b0, 8'd3, 2'b10);
      applyStimulus(1'b1, 1'b0, 8'd3, 2'b11);
      checkOutput("s2_rv_early", 32'(result_valid), 32'd0);
      applyStimulus(1'b1, 1'b0, 8'd3, 2'b11);
      checkOutput("s2_rv", 32'(result_valid), 32'd1);
      checkResult("s2", 16'h0300, 1'b1, 1'b0);

      // Scenario 3: full-length windows with both neurons firing every tick.
      $display("[TB] scenario 3");
      applyStimulus(1'b0, 1'b1, 8'd255, 2'b11);
      for (int i = 0; i < 255; i++) begin
         applyStimulus(1'b1, 1'b0, 8'd255, 2'b11);
      end
      waitResult("s3a", 2);
      checkResult("s3a", 16'hFFFF, 1'b0, 1'b1);
      applyStimulus(1'b0, 1'b1, 8'd255, 2'b11);
      for (int i = 0; i < 255; i++) begin
         applyStimulus(1'b1, 1'b0, 8'd255, 2'b11);
      end
      waitResult("s3b", 2);
      checkResult("s3b", 16'hFFFF, 1'b0, 1'b1);

      // Scenario 4: zero-length window.
      $display("[TB] scenario 4");
      applyStimulus(1'b1, 1'b1, 8'd0, 2'b11);
      checkOutput("s4_busy", 32'(busy), 32'd1);
      checkOutput("s4_rv0", 32'(result_valid), 32'd0);
      applyStimulus(1'b1, 1'b0, 8'd0, 2'b11);
      checkOutput("s4_rv1", 32'(result_valid), 32'd0);
      applyStimulus(1'b1, 1'b0, 8'd0, 2'b11);
      checkOutput("s4_rv2", 32'(result_valid), 32'd1);
      checkResult("s4", 16'h0000, 1'b0, 1'b1);

      // Scenario 5: reset mid-window, then start ignored while busy.
      $display("[TB] scenario 5");
      applyStimulus(1'b0, 1'b1, 8'd5, 2'b00);
      applyStimulus(1'b1, 1'b1, 8'd1, 2'b01);
      applyStimulus(1'b1, 1'b0, 8'd5, 2'b01);
      reset = 1'b0;
      #2;
      checkOutput("s5_rst_busy", 32'(busy), 32'd0);
      checkOutput("s5_rst_rv", 32'(result_valid), 32'd0);
      checkResult("s5_rst", 16'h0000, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      reset = 1'b1;
      rv_base = rv_count;
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b1, 1'b0, 8'd1, 2'b11);
      end
      checkOutput("s5_idle_busy", 32'(busy), 32'd0);
      checkOutput("s5_idle_pulses", 32'(rv_count - rv_base), 32'd0);
      applyStimulus(1'b0, 1'b1, 8'd2, 2'b00);
      applyStimulus(1'b1, 1'b1, 8'd4, 2'b01);
      applyStimulus(1'b1, 1'b1, 8'd4, 2'b01);
      applyStimulus(1'b0, 1'b0, 8'd0, 2'b00);
      applyStimulus(1'b0, 1'b0, 8'd0, 2'b00);
      checkOutput("s5_ign_rv", 32'(result_valid), 32'd1);
      checkResult("s5_ign", 16'h0002, 1'b0, 1'b0);

      // Scenario 6: start held through result_valid gives a back-to-back window.
      $display("[TB] scenario 6");
      applyStimulus(1'b1, 1'b1, 8'd2, 2'b00);
      applyStimulus(1'b1, 1'b0, 8'd2, 2'b10);
      applyStimulus(1'b1, 1'b1, 8'd1, 2'b10);
      applyStimulus(1'b1, 1'b1, 8'd1, 2'b10);
      applyStimulus(1'b1, 1'b1, 8'd1, 2'b10);
      checkOutput("s6a_rv", 32'(result_valid), 32'd1);
      checkResult("s6a", 16'h0200, 1'b1, 1'b0);
      applyStimulus(1'b1, 1'b1, 8'd1, 2'b01);
      checkOutput("s6_restart_busy", 32'(busy), 32'd1);
      checkOutput("s6_restart_rv", 32'(result_valid), 32'd0);
      applyStimulus(1'b1, 1'b0, 8'd1, 2'b01);
      applyStimulus(1'b0, 1'b0, 8'd0, 2'b00);
      applyStimulus(1'b0, 1'b0, 8'd0, 2'b00);
      checkOutput("s6b_rv", 32'(result_valid), 32'd1);
      checkResult("s6b", 16'h0001, 1'b0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, mismatch_count);
      $finish;
   end

endmodule
